output_port_tx: RTL and testbench

OUTPUT_PORT_TX -- requirements
Module: output_port_tx

---
 rtl/output_port_tx.sv | 155 +++++++++++++++
 tb/tb_output_port_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/output_port_tx.sv
// Serialises the 24-bit output-port register over an 8N1 line whenever it changes.
// Three bytes per frame, most significant byte first, each byte LSB first.
module output_port_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] portData,
    input  logic        enable,
    output logic        txd,
    output logic        busy,
    output logic        pending,
    output logic [7:0]  overrunCount
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } stateT;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    stateT       state;
    stateT       stateNext;
    logic [15:0] bitCnt;
    logic [15:0] bitCntNext;
    logic [2:0]  bitIdx;
    logic [2:0]  bitIdxNext;
    logic [1:0]  byteIdx;
    logic [1:0]  byteIdxNext;
    logic [23:0] shadow;
    logic [23:0] holdReg;
    logic [23:0] shiftReg;
    logic [7:0]  curByte;
    logic        capture;
    logic        load;
    logic        bitDone;

    assign capture = enable && (portData != shadow);
    assign bitDone = (bitCnt == BIT_LAST);

    // Shadow and holdReg reset to the register file's reset value so reset release looks like "no change".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow       <= 24'hFFFFFF;
            holdReg      <= 24'hFFFFFF;
            pending      <= 1'b0;
            overrunCount <= 8'd0;
        end else begin
            shadow <= portData;
            if (capture) begin
                holdReg <= portData;
                pending <= 1'b1;
                if (pending && !load && (overrunCount != 8'hFF)) begin
                    overrunCount <= overrunCount + 8'd1;
                end
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bitCnt   <= 16'd0;
            bitIdx   <= 3'd0;
            byteIdx  <= 2'd0;
            shiftReg <= 24'd0;
        end else begin
            state   <= stateNext;
            bitCnt  <= bitCntNext;
            bitIdx  <= bitIdxNext;
            byteIdx <= byteIdxNext;
            if (load) begin
                shiftReg <= holdReg;
            end
        end
    end

    always_comb begin
        case (byteIdx)
            2'd0:    curByte = shiftReg[23:16];
            2'd1:    curByte = shiftReg[15:8];
            default: curByte = shiftReg[7:0];
        endcase
    end

    // txd and busy decode straight from state so an asynchronous reset idles the line at once.
    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        load        = 1'b0;
        txd         = 1'b1;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy        = 1'b0;
                bitCntNext  = 16'd0;
                bitIdxNext  = 3'd0;
                byteIdxNext = 2'd0;
                if (pending) begin
                    load      = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (bitDone) begin
                    bitCntNext = 16'd0;
                    stateNext  = DATA;
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            DATA: begin
                txd = curByte[bitIdx];
                if (bitDone) begin
                    bitCntNext = 16'd0;
                    if (bitIdx == 3'd7) begin
                        bitIdxNext = 3'd0;
                        stateNext  = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            STOP: begin
                txd = 1'b1;
                if (bitDone) begin
                    bitCntNext = 16'd0;
                    if (byteIdx == 2'd2) begin
                        byteIdxNext = 2'd0;
                        stateNext   = IDLE;
                    end else begin
                        byteIdxNext = byteIdx + 2'd1;
                        stateNext   = START;
                    end
                end else begin
                    bitCntNext = bitCnt + 16'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_output_port_tx.sv
// Directed bench for output_port_tx at 4 clocks per bit.
// Frames are decoded by sampling the second clock of every serial bit.
module tb_output_port_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] portData;
    logic        enable;
    logic        txd;
    logic        busy;
    logic        pending;
    logic [7:0]  overrunCount;

    int compCount = 0;
    int failCount = 0;

    output_port_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .portData(portData),
        .enable(enable),
        .txd(txd),
        .busy(busy),
        .pending(pending),
        .overrunCount(overrunCount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] data, input logic en);
        portData = data;
        enable   = en;
    endtask

    task automatic idleWatch(input int cycles, output logic sawActivity);
        sawActivity = 1'b0;
        repeat (cycles) begin
            step();
            if (txd !== 1'b1 || busy !== 1'b0 || pending !== 1'b0) sawActivity = 1'b1;
        end
    endtask

    task automatic waitStart(input int budget, output int latency, output logic found);
        found   = 1'b0;
        latency = 0;
        while (!found && latency < budget) begin
            step();
            latency++;
            if (txd === 1'b0) found = 1'b1;
        end
    endtask

    // Called one tick after the edge where txd fell; returns at the sample of the last stop bit.
    task automatic receiveFrame(output logic [23:0] data, output logic framingOk);
        int bitPos;
        int byteN;
        data      = 24'd0;
        framingOk = 1'b1;
        step();
        for (int k = 0; k < 30; k++) begin
            if (k > 0) repeat (CPB) step();
            bitPos = k % 10;
            byteN  = k / 10;
            if (bitPos == 0) begin
                if (txd !== 1'b0) framingOk = 1'b0;
            end else if (bitPos == 9) begin
                if (txd !== 1'b1) framingOk = 1'b0;
            end else begin
                data[16 - 8 * byteN + bitPos - 1] = txd;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] rx;
        logic        ok;
        logic        act;
        logic        found;
        int          lat;

        rst = 1'b1;
        applyStimulus(24'hFFFFFF, 1'b1);
        repeat (3) step();
        checkOutput("resetTxd", txd, 1);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetPending", pending, 0);
        checkOutput("resetOverrun", overrunCount, 0);
        rst = 1'b0;
        idleWatch(200, act);
        checkOutput("quietAfterReset", act, 0);

        applyStimulus(24'hA53C0F, 1'b1);
        step();
        checkOutput("pendingSet", pending, 1);
        checkOutput("txdHighAtCapture", txd, 1);
        step();
        checkOutput("txdFallNextEdge", txd, 0);
        checkOutput("busyAtStart", busy, 1);
        checkOutput("pendingCleared", pending, 0);
        receiveFrame(rx, ok);
        checkOutput("frameA53C0F", rx, 24'hA53C0F);
        checkOutput("framingA53C0F", ok, 1);
        repeat (2) step();
        checkOutput("busyLastCycle", busy, 1);
        step();
        checkOutput("busyAfter120", busy, 0);

        // Second change lands on the load edge: queued, no overrun.
        applyStimulus(24'h111111, 1'b1);
        step();
        applyStimulus(24'h222222, 1'b1);
        step();
        checkOutput("simulTxd", txd, 0);
        checkOutput("simulPending", pending, 1);
        checkOutput("simulOverrun", overrunCount, 0);
        receiveFrame(rx, ok);
        checkOutput("frame111111", rx, 24'h111111);
        checkOutput("framing111111", ok, 1);
        repeat (3) step();
        checkOutput("gapTxd", txd, 1);
        checkOutput("gapBusy", busy, 0);
        checkOutput("gapPending", pending, 1);
        step();
        checkOutput("backToBackStart", txd, 0);
        receiveFrame(rx, ok);
        checkOutput("frame222222", rx, 24'h222222);
        checkOutput("framing222222", ok, 1);
        repeat (3) step();
        checkOutput("simulEndBusy", busy, 0);
        checkOutput("simulEndPending", pending, 0);
        checkOutput("simulEndOverrun", overrunCount, 0);

        applyStimulus(24'h000001, 1'b1);
        step();
        applyStimulus(24'h000002, 1'b1);
        step();
        checkOutput("rapidTxdFall", txd, 0);
        applyStimulus(24'h000003, 1'b1);
        receiveFrame(rx, ok);
        checkOutput("frame000001", rx, 24'h000001);
        checkOutput("framing000001", ok, 1);
        repeat (3) step();
        checkOutput("rapidPending", pending, 1);
        step();
        checkOutput("rapidSecondStart", txd, 0);
        receiveFrame(rx, ok);
        checkOutput("frame000003", rx, 24'h000003);
        checkOutput("framing000003", ok, 1);
        repeat (3) step();
        checkOutput("rapidEndBusy", busy, 0);
        checkOutput("rapidOverrun", overrunCount, 1);

        // Reset at frame cycle 50 while the line is low in the middle byte.
        applyStimulus(24'h0F000F, 1'b1);
        step();
        step();
        checkOutput("midFrameStart", txd, 0);
        repeat (49) step();
        checkOutput("preResetTxd", txd, 0);
        #2;
        rst = 1'b1;
        applyStimulus(24'hFFFFFF, 1'b1);
        #1;
        checkOutput("rstTxdAsync", txd, 1);
        checkOutput("rstBusyAsync", busy, 0);
        checkOutput("rstPendingAsync", pending, 0);
        checkOutput("rstOverrunAsync", overrunCount, 0);
        repeat (2) step();
        rst = 1'b0;
        idleWatch(150, act);
        checkOutput("noFrameAfterRst", act, 0);
        applyStimulus(24'h123456, 1'b1);
        waitStart(10, lat, found);
        checkOutput("startFound123456", found, 1);
        checkOutput("latency123456", lat, 2);
        receiveFrame(rx, ok);
        checkOutput("frame123456", rx, 24'h123456);
        checkOutput("framing123456", ok, 1);
        repeat (3) step();
        checkOutput("endBusy123456", busy, 0);

        applyStimulus(24'h00FF00, 1'b0);
        idleWatch(20, act);
        checkOutput("disabledNoFrame", act, 0);
        applyStimulus(24'h00FF00, 1'b1);
        idleWatch(150, act);
        checkOutput("reenabledNoFrame", act, 0);
        checkOutput("reenabledPending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
